game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/flappy_pkg.sv | 18 +
 rtl/button_conditioner.sv | 48 ++++
 rtl/game_sequencer.sv | 165 ++++++++++++++++
 tb/tb_game_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game sequencer: state encoding, state
// width and banner blink period.
package flappy_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READY = 3'd1;
  localparam state_t ST_PLAY  = 3'd2;
  localparam state_t ST_HIT   = 3'd3;
  localparam state_t ST_OVER  = 3'd4;

  localparam int unsigned BLINK_PERIOD = 16;
  localparam int unsigned BLINK_W      = $clog2(BLINK_PERIOD);

endpackage

// File: rtl/button_conditioner.sv
// Player button conditioning: 2-flop synchroniser, rising-edge detect and a
// frame-counted lockout that discards (never queues) presses while active.
module button_conditioner #(
  parameter int unsigned LOCKOUT_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  input  logic frame_tick_i,
  input  logic accept_en_i,
  output logic press_o
);

  logic       sync1_q, sync2_q, prev_q, press_q;
  logic [3:0] lock_q, lock_d;
  logic       rise, accept;

  assign rise   = sync2_q & ~prev_q;
  assign accept = rise & accept_en_i & (lock_q == '0);

  always_comb begin
    lock_d = lock_q;
    if (accept) begin
      lock_d = 4'(LOCKOUT_FRAMES);
    end else if (frame_tick_i && (lock_q != '0)) begin
      lock_d = lock_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      lock_q  <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= accept;
      lock_q  <= lock_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Flappy game sequencer: IDLE/READY/PLAY/HIT/OVER FSM driven by frame ticks
// derived from v_sync. Define HISCORE_EN to build the high-score register.
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int unsigned READY_FRAMES   = 60,
  parameter int unsigned HIT_FRAMES     = 30,
  parameter int unsigned LOCKOUT_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               v_sync,
  input  logic               game_button,
  input  logic               collide,
  input  logic [7:0]         score_in,
  output logic               run_en,
  output logic               physics_rst,
  output logic               flap,
  output logic [STATE_W-1:0] state,
  output logic               blink,
  output logic [7:0]         hi_score
);

  logic               vs_q, tick_q;
  logic               press;
  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d, cnt_inc;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               blink_q, blink_d;
  logic               run_en_q, run_en_d;
  logic               prst_q, prst_d;
  logic               flap_q, flap_d;

  button_conditioner #(
    .LOCKOUT_FRAMES(LOCKOUT_FRAMES)
  ) u_button (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_i     (game_button),
    .frame_tick_i (tick_q),
    .accept_en_i  (state_q != ST_HIT),
    .press_o      (press)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    prst_d  = 1'b0;
    flap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_READY;
          cnt_d   = '0;
          prst_d  = 1'b1;
        end
      end
      ST_READY: begin
        if (tick_q) begin
          if (cnt_inc == 8'(READY_FRAMES)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_PLAY: begin
        // collision takes priority over a press arriving in the same cycle
        if (collide) begin
          state_d = ST_HIT;
          cnt_d   = '0;
        end else if (press) begin
          flap_d = 1'b1;
        end
      end
      ST_HIT: begin
        if (tick_q) begin
          if (cnt_inc == 8'(HIT_FRAMES)) begin
            state_d = ST_OVER;
            cnt_d   = '0;
            bcnt_d  = '0;
            blink_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_OVER: begin
        if (press) begin
          state_d = ST_READY;
          cnt_d   = '0;
          bcnt_d  = '0;
          blink_d = 1'b0;
          prst_d  = 1'b1;
        end else if (tick_q) begin
          bcnt_d = bcnt_q + BLINK_W'(1);
          if (bcnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
            blink_d = ~blink_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bcnt_d  = '0;
        blink_d = 1'b0;
      end
    endcase
    run_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      tick_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      blink_q  <= 1'b0;
      run_en_q <= 1'b0;
      prst_q   <= 1'b0;
      flap_q   <= 1'b0;
    end else begin
      vs_q     <= v_sync;
      tick_q   <= vs_q & ~v_sync;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      run_en_q <= run_en_d;
      prst_q   <= prst_d;
      flap_q   <= flap_d;
    end
  end

`ifdef HISCORE_EN
  logic [7:0] hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
    end else if ((state_q == ST_HIT) && (state_d == ST_OVER) && (score_in > hi_q)) begin
      hi_q <= score_in;
    end
  end

  assign hi_score = hi_q;
`else
  logic unused_score;
  assign unused_score = ^score_in;
  assign hi_score     = '0;
`endif

  assign run_en      = run_en_q;
  assign physics_rst = prst_q;
  assign flap        = flap_q;
  assign state       = state_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected output
// snapshots, a negedge monitor compares them whenever any output changes.
module tb_game_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic       run;
    logic       prst;
    logic       flp;
    logic       blk;
    logic [7:0] hi;
  } rec_t;

`ifdef HISCORE_EN
  localparam logic [7:0] HI1 = 8'd12;
`else
  localparam logic [7:0] HI1 = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v_sync = 1'b1;
  logic       game_button = 1'b0;
  logic       collide = 1'b0;
  logic [7:0] score_in = 8'd0;
  logic       run_en, physics_rst, flap, blink;
  logic [2:0] state;
  logic [7:0] hi_score;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        mon_en = 1'b0;
  logic        snap_req = 1'b0;
  rec_t        expq[$];
  string       nameq[$];

  always #20 clk = ~clk;

  game_sequencer #(
    .READY_FRAMES(60),
    .HIT_FRAMES(30),
    .LOCKOUT_FRAMES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .v_sync      (v_sync),
    .game_button (game_button),
    .collide     (collide),
    .score_in    (score_in),
    .run_en      (run_en),
    .physics_rst (physics_rst),
    .flap        (flap),
    .state       (state),
    .blink       (blink),
    .hi_score    (hi_score)
  );

  function automatic rec_t mk(input logic [2:0] st, input logic run, input logic prst,
                              input logic flp, input logic blk, input logic [7:0] hi);
    rec_t r;
    r.st = st; r.run = run; r.prst = prst; r.flp = flp; r.blk = blk; r.hi = hi;
    return r;
  endfunction

  task automatic expect_ev(input string name, input rec_t r);
    expq.push_back(r);
    nameq.push_back(name);
  endtask

  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk) v_sync = 1'b0;
      repeat (2) @(negedge clk);
      v_sync = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic press();
    @(negedge clk) game_button = 1'b1;
    repeat (6) @(negedge clk);
    game_button = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // press_q reaches the FSM on the 4th edge after the button rises
  task automatic press_with_collide();
    @(negedge clk) game_button = 1'b1;
    repeat (3) @(negedge clk);
    collide = 1'b1;
    @(negedge clk) collide = 1'b0;
    repeat (3) @(negedge clk);
    game_button = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic snapshot();
    @(posedge clk) snap_req = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_game(input logic [7:0] hi);
    expect_ev("idle_press_prst", mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, hi));
    expect_ev("ready_prst_end", mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, hi));
    press();
    frames(59);
    expect_ev("ready_to_play", mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, hi));
    frames(1);
  endtask

  initial begin : monitor
    rec_t prev, cur, exp;
    string nm;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = mk(state, run_en, physics_rst, flap, blink, hi_score);
      if (mon_en && ((cur != prev) || snap_req)) begin
        snap_req = 1'b0;
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got st=%0d run=%0d prst=%0d flap=%0d blink=%0d hi=%0d, required no output change",
                   cur.st, cur.run, cur.prst, cur.flp, cur.blk, cur.hi);
        end else begin
          exp = expq.pop_front();
          nm  = nameq.pop_front();
          if (cur !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d run=%0d prst=%0d flap=%0d blink=%0d hi=%0d, required st=%0d run=%0d prst=%0d flap=%0d blink=%0d hi=%0d",
                     nm, cur.st, cur.run, cur.prst, cur.flp, cur.blk, cur.hi,
                     exp.st, exp.run, exp.prst, exp.flp, exp.blk, exp.hi);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
    expect_ev("reset_state", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    snapshot();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // game 1
    start_game(8'd0);
    expect_ev("flap_pulse", mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0));
    expect_ev("flap_end", mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    press();
    frames(1);
    press();                 // inside lockout: discarded
    frames(2);
    expect_ev("flap_after_lockout", mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0));
    expect_ev("flap_after_lockout_end", mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    press();
    frames(3);
    score_in = 8'd12;
    expect_ev("collide_wins", mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    press_with_collide();
    frames(5);
    press();                 // HIT: discarded
    frames(24);
    expect_ev("hit_to_over", mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, HI1));
    frames(1);
    frames(15);
    expect_ev("blink_off_16", mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, HI1));
    frames(1);
    frames(15);
    expect_ev("blink_on_32", mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, HI1));
    frames(1);
    expect_ev("over_press_prst", mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, HI1));
    expect_ev("over_prst_end", mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, HI1));
    press();

    // game 2: lower score keeps the best
    frames(59);
    expect_ev("ready_to_play_g2", mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, HI1));
    frames(1);
    score_in = 8'd7;
    expect_ev("collide_g2", mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, HI1));
    @(negedge clk) collide = 1'b1;
    @(negedge clk) collide = 1'b0;
    repeat (3) @(negedge clk);
    frames(29);
    expect_ev("over_g2_hi_held", mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, HI1));
    frames(1);

    // game 3: reset mid-play
    expect_ev("over_press_g3", mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, HI1));
    expect_ev("over_prst_end_g3", mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, HI1));
    press();
    frames(59);
    expect_ev("ready_to_play_g3", mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, HI1));
    frames(1);
    expect_ev("async_reset", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(posedge clk) #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_ev("after_reset_idle", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    snapshot();
    start_game(8'd0);

    repeat (10) @(negedge clk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d pending (next %s), required 0 pending",
               expq.size(), nameq[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
